// File: rtl/fft_stage_ctrl.sv
// Radix-2 in-place FFT address/sequencing controller: issues N/2 butterflies per stage, drains the
// butterfly pipeline between stages. Define FFT_STALL_EN to add a stall input that pauses read issue.
module fft_stage_ctrl #(
    parameter int LOG2N    = 4,
    parameter int BFLY_LAT = 2,
    localparam int SW      = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FFT_STALL_EN
    input  logic             stall,
`endif
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_p,
    output logic [LOG2N-1:0] rd_addr_q,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_p,
    output logic [LOG2N-1:0] wr_addr_q,
    output logic [SW-1:0]    stage,
    output logic             busy,
    output logic             done
);

    localparam int KW = LOG2N - 1;
    localparam int D  = BFLY_LAT + 1;
    localparam int CW = $clog2(D + 1);
    localparam int PW = 2 * LOG2N + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              r_state;
    logic [KW-1:0]       r_k;
    logic [SW-1:0]       r_s;
    logic [CW-1:0]       r_cnt;
    logic                r_rd_en;
    logic [LOG2N-1:0]    r_rd_p;
    logic [LOG2N-1:0]    r_rd_q;
    logic [LOG2N-2:0]    r_tw;
    logic [SW-1:0]       r_stage;
    logic                r_busy;
    logic                r_done;
    logic [D-1:0][PW-1:0] r_pipe;

    logic                w_stall;
    logic [LOG2N-1:0]    w_one;
    logic [LOG2N-1:0]    w_k_ext;
    logic [LOG2N-1:0]    w_mask;
    logic [LOG2N-1:0]    w_p;
    logic [LOG2N-1:0]    w_tw_full;

`ifdef FFT_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Operand p inserts a zero bit at position s of k; q sets that bit.
    assign w_one     = {{(LOG2N-1){1'b0}}, 1'b1};
    assign w_k_ext   = {1'b0, r_k};
    assign w_mask    = (w_one << r_s) - w_one;
    assign w_p       = ((w_k_ext >> r_s) << (32'(r_s) + 32'd1)) | (w_k_ext & w_mask);
    assign w_tw_full = (w_k_ext & w_mask) << (LOG2N - 1 - 32'(r_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_rd_en <= 1'b0;
            r_rd_p  <= '0;
            r_rd_q  <= '0;
            r_tw    <= '0;
            r_stage <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_busy  <= (r_state != IDLE);
            r_done  <= (r_state == DONE);
            r_stage <= r_s;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_k     <= '0;
                        r_s     <= '0;
                    end
                end
                RUN: begin
                    if (!w_stall) begin
                        r_rd_en <= 1'b1;
                        r_rd_p  <= w_p;
                        r_rd_q  <= w_p | (w_one << r_s);
                        r_tw    <= w_tw_full[LOG2N-2:0];
                        r_k     <= r_k + KW'(1);
                        if (r_k == KW'((1 << KW) - 1)) begin
                            r_state <= DRAIN;
                            r_cnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cnt == CW'(D - 1)) begin
                        if (r_s == SW'(LOG2N - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                            r_s     <= r_s + SW'(1);
                            r_k     <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Write-back strobe and addresses trail the issued read by D cycles regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[D-2:0], {r_rd_en, r_rd_p, r_rd_q}};
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr_p = r_rd_p;
    assign rd_addr_q = r_rd_q;
    assign tw_addr   = r_tw;
    assign stage     = r_stage;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_en     = r_pipe[D-1][PW-1];
    assign wr_addr_p = r_pipe[D-1][2*LOG2N-1:LOG2N];
    assign wr_addr_q = r_pipe[D-1][LOG2N-1:0];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl (N=16, BFLY_LAT=2): compares every cycle of several runs against an
// issue-schedule model, with random ignored start pulses, random gaps and a mid-run reset.
module tb_fft_stage_ctrl;
    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int H     = N / 2;
    localparam int D     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
`ifdef FFT_STALL_EN
    logic       stall = 1'b0;
`endif
    logic       rd_en, wr_en, busy, done;
    logic [3:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
    logic [2:0] tw_addr;
    logic [1:0] stage;

    int total = 0;
    int bad   = 0;
    int exp_rd [0:99];
    int exp_p  [0:99];
    int exp_q  [0:99];
    int exp_tw [0:99];
    int exp_st [0:99];
    int done_c;

    fft_stage_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT_STALL_EN
        .stall(stall),
`endif
        .rd_en(rd_en), .rd_addr_p(rd_addr_p), .rd_addr_q(rd_addr_q), .tw_addr(tw_addr),
        .wr_en(wr_en), .wr_addr_p(wr_addr_p), .wr_addr_q(wr_addr_q),
        .stage(stage), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag, input int c);
        chk({tag, "_rd_en"}, c, 32'(rd_en), 0);
        chk({tag, "_wr_en"}, c, 32'(wr_en), 0);
        chk({tag, "_busy"},  c, 32'(busy), 0);
        chk({tag, "_done"},  c, 32'(done), 0);
        chk({tag, "_addrs"}, c, {8'd0, rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q, 1'b0, tw_addr, 2'd0, stage}, 0);
    endtask

    // Butterfly k of stage s reads at the k-th non-stalled edge of that stage; stages are
    // separated by D idle edges; done follows the last drain.
    task automatic build_model(input int st_from, input int st_n);
        int pos;
        int m;
        for (int i = 0; i < 100; i++) exp_rd[i] = 0;
        pos = 1;
        for (int s = 0; s < LOG2N; s++) begin
            m = 1 << s;
            for (int k = 0; k < H; k++) begin
                while (pos >= st_from && pos < st_from + st_n) pos++;
                exp_rd[pos] = 1;
                exp_p[pos]  = (k / m) * (2 * m) + (k % m);
                exp_q[pos]  = exp_p[pos] + m;
                exp_tw[pos] = (k % m) * (H / m);
                exp_st[pos] = s;
                pos++;
            end
            pos += D;
        end
        done_c = pos;
    endtask

    task automatic run(input int rst_at, input int st_from, input int st_n);
        int wr_exp;
        build_model(st_from, st_n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= done_c + 1; c++) begin
            if (c > 0) begin
                start = (c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef FFT_STALL_EN
                stall = (c >= st_from && c < st_from + st_n);
`endif
                tick();
                start = 1'b0;
            end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 chk_all_zero("rst_async", c);
                tick();
                chk_all_zero("rst_held", c + 1);
                #2 rst = 1'b0;
                return;
            end
            chk("rd_en", c, 32'(rd_en), 32'(exp_rd[c]));
            if (exp_rd[c] != 0) begin
                chk("rd_addr_p", c, 32'(rd_addr_p), 32'(exp_p[c]));
                chk("rd_addr_q", c, 32'(rd_addr_q), 32'(exp_q[c]));
                chk("tw_addr",   c, 32'(tw_addr),   32'(exp_tw[c]));
                chk("stage",     c, 32'(stage),     32'(exp_st[c]));
            end
            wr_exp = (c >= D) ? exp_rd[c-D] : 0;
            chk("wr_en", c, 32'(wr_en), 32'(wr_exp));
            if (wr_exp != 0) begin
                chk("wr_addr_p", c, 32'(wr_addr_p), 32'(exp_p[c-D]));
                chk("wr_addr_q", c, 32'(wr_addr_q), 32'(exp_q[c-D]));
            end
            chk("busy", c, 32'(busy), (c >= 1 && c <= done_c) ? 32'd1 : 32'd0);
            chk("done", c, 32'(done), (c == done_c) ? 32'd1 : 32'd0);
        end
        $display("run complete: rst_at=%0d stall_from=%0d stall_n=%0d done_cycle=%0d", rst_at, st_from, st_n, done_c);
    endtask

    initial begin
        tick();
        chk_all_zero("reset", 0);
        tick();
        #2 rst = 1'b0;
        tick();
        chk_all_zero("idle", 0);
        run(-1, -1, 0);
        repeat ($urandom_range(0, 3)) tick();
        run(-1, -1, 0);
        repeat ($urandom_range(1, 4)) tick();
        run(20, -1, 0);
        run(-1, -1, 0);
`ifdef FFT_STALL_EN
        repeat (2) tick();
        run(-1, 3, 3);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
